// File: rtl/fmc_adc_shot_seq_pkg.sv
// Shared state encoding for the multi-shot acquisition sequencer.
// The CSR status FSM field decodes the same values.

package fmc_adc_shot_seq_pkg;

    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_PRE_TRIG  = 3'd1;
    localparam logic [2:0] C_ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] C_ST_POST_TRIG = 3'd3;
    localparam logic [2:0] C_ST_TAG_WR    = 3'd4;
    localparam logic [2:0] C_ST_NEXT_SHOT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = C_ST_IDLE,
        ST_PRE_TRIG  = C_ST_PRE_TRIG,
        ST_WAIT_TRIG = C_ST_WAIT_TRIG,
        ST_POST_TRIG = C_ST_POST_TRIG,
        ST_TAG_WR    = C_ST_TAG_WR,
        ST_NEXT_SHOT = C_ST_NEXT_SHOT
    } t_shot_seq_state;

    // States in which incoming ADC samples go to the sample buffer.
    function automatic logic is_sampling_state(input t_shot_seq_state st);
        return (st == ST_PRE_TRIG) || (st == ST_WAIT_TRIG) || (st == ST_POST_TRIG);
    endfunction

endpackage

// File: rtl/fmc_adc_sample_counter.sv
// Up-counter cleared to zero on demand, saturating at a target value.
// hit_o flags the increment that lands exactly on the target.

module fmc_adc_sample_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] target_i,
    output logic             at_target_o,
    output logic             hit_o
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_inc;

    assign count_inc   = count_q + C_ONE;
    assign at_target_o = (count_q == target_i);
    assign hit_o       = inc_i && !at_target_o && (count_inc == target_i);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !at_target_o) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fmc_adc_shot_sequencer.sv
// Multi-shot acquisition sequencer: pre-trigger, trigger wait and post-trigger
// sample phases per shot, timetag request per shot, one end pulse per run.
//
// state      | meaning
// IDLE       | no run active, waiting for a valid start
// PRE_TRIG   | collecting the latched number of pre-trigger samples
// WAIT_TRIG  | buffering samples until the arbitrated trigger arrives
// POST_TRIG  | collecting the latched number of post-trigger samples
// TAG_WR     | one-cycle timetag write request for the finished shot
// NEXT_SHOT  | decrement remaining shots, end the run on the last one

module fmc_adc_shot_sequencer
    import fmc_adc_shot_seq_pkg::*;
#(
    parameter int g_SAMPLE_CNT_WIDTH = 32,
    parameter int g_SHOT_CNT_WIDTH   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic [g_SAMPLE_CNT_WIDTH-1:0] pre_samples_i,
    input  logic [g_SAMPLE_CNT_WIDTH-1:0] post_samples_i,
    input  logic [g_SHOT_CNT_WIDTH-1:0]   shots_i,
    input  logic                          sample_valid_i,
    input  logic                          trig_i,
    output logic                          cfg_ok_o,
    output logic [2:0]                    state_o,
    output logic                          wait_trig_o,
    output logic                          sample_wr_o,
    output logic                          tag_wr_o,
    output logic                          acq_end_o,
    output logic [g_SHOT_CNT_WIDTH-1:0]   shots_left_o
);

    localparam logic [g_SHOT_CNT_WIDTH-1:0] C_SHOT_ONE = g_SHOT_CNT_WIDTH'(1);

    t_shot_seq_state state_q, state_d;

    logic [g_SAMPLE_CNT_WIDTH-1:0] pre_q, pre_d;
    logic [g_SAMPLE_CNT_WIDTH-1:0] post_q, post_d;
    logic [g_SHOT_CNT_WIDTH-1:0]   shots_left_q, shots_left_d;
    logic                          sample_wr_q, sample_wr_d;
    logic                          tag_wr_q, tag_wr_d;
    logic                          acq_end_q, acq_end_d;
    logic                          wait_trig_q, wait_trig_d;

    logic cfg_ok;
    logic run_start;
    logic abort;
    logic cnt_clr;
    logic pre_inc, pre_at, pre_hit;
    logic post_inc, post_at, post_hit;

    assign cfg_ok    = (shots_i != '0) && (post_samples_i != '0);
    assign run_start = (state_q == ST_IDLE) && start_i && !stop_i && cfg_ok;
    assign abort     = (state_q != ST_IDLE) && stop_i;

    // Counters restart at every shot boundary and stay at zero while idle.
    assign cnt_clr  = (state_q == ST_IDLE) || (state_q == ST_NEXT_SHOT);
    assign pre_inc  = (state_q == ST_PRE_TRIG) && sample_valid_i;
    assign post_inc = (state_q == ST_POST_TRIG) && sample_valid_i;

    fmc_adc_sample_counter #(
        .WIDTH(g_SAMPLE_CNT_WIDTH)
    ) u_pre_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (cnt_clr),
        .inc_i      (pre_inc),
        .target_i   (pre_q),
        .at_target_o(pre_at),
        .hit_o      (pre_hit)
    );

    fmc_adc_sample_counter #(
        .WIDTH(g_SAMPLE_CNT_WIDTH)
    ) u_post_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (cnt_clr),
        .inc_i      (post_inc),
        .target_i   (post_q),
        .at_target_o(post_at),
        .hit_o      (post_hit)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            pre_q        <= '0;
            post_q       <= '0;
            shots_left_q <= '0;
            sample_wr_q  <= 1'b0;
            tag_wr_q     <= 1'b0;
            acq_end_q    <= 1'b0;
            wait_trig_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            shots_left_q <= shots_left_d;
            sample_wr_q  <= sample_wr_d;
            tag_wr_q     <= tag_wr_d;
            acq_end_q    <= acq_end_d;
            wait_trig_q  <= wait_trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_start) begin
                        state_d = ST_PRE_TRIG;
                    end
                end
                ST_PRE_TRIG: begin
                    // pre_at alone only holds for a zero pre-sample count.
                    if (pre_at || pre_hit) begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_i) begin
                        state_d = ST_POST_TRIG;
                    end
                end
                ST_POST_TRIG: begin
                    if (post_at || post_hit) begin
                        state_d = ST_TAG_WR;
                    end
                end
                ST_TAG_WR: begin
                    state_d = ST_NEXT_SHOT;
                end
                ST_NEXT_SHOT: begin
                    if (shots_left_q == C_SHOT_ONE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PRE_TRIG;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pre_d        = pre_q;
        post_d       = post_q;
        shots_left_d = shots_left_q;
        if (run_start) begin
            pre_d        = pre_samples_i;
            post_d       = post_samples_i;
            shots_left_d = shots_i;
        end else if (abort) begin
            shots_left_d = '0;
        end else if (state_q == ST_NEXT_SHOT) begin
            shots_left_d = shots_left_q - C_SHOT_ONE;
        end

        sample_wr_d = sample_valid_i && is_sampling_state(state_q);
        wait_trig_d = (state_d == ST_WAIT_TRIG);
        tag_wr_d    = (state_d == ST_TAG_WR);
        acq_end_d   = (state_q == ST_NEXT_SHOT) && !abort && (shots_left_q == C_SHOT_ONE);
    end

    assign cfg_ok_o     = cfg_ok;
    assign state_o      = state_q;
    assign wait_trig_o  = wait_trig_q;
    assign sample_wr_o  = sample_wr_q;
    assign tag_wr_o     = tag_wr_q;
    assign acq_end_o    = acq_end_q;
    assign shots_left_o = shots_left_q;

endmodule

// File: tb/tb_fmc_adc_shot_sequencer.sv
// Directed bench for the shot sequencer: hand-computed state, pulse and
// write-count expectations per scenario.

module tb_fmc_adc_shot_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] pre_samples;
    logic [31:0] post_samples;
    logic [15:0] shots;
    logic        sample_valid;
    logic        trig;
    logic        cfg_ok;
    logic [2:0]  state;
    logic        wait_trig;
    logic        sample_wr;
    logic        tag_wr;
    logic        acq_end;
    logic [15:0] shots_left;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int tag_cnt  = 0;
    int acq_cnt  = 0;

    fmc_adc_shot_sequencer #(
        .g_SAMPLE_CNT_WIDTH(32),
        .g_SHOT_CNT_WIDTH  (16)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .stop_i        (stop),
        .pre_samples_i (pre_samples),
        .post_samples_i(post_samples),
        .shots_i       (shots),
        .sample_valid_i(sample_valid),
        .trig_i        (trig),
        .cfg_ok_o      (cfg_ok),
        .state_o       (state),
        .wait_trig_o   (wait_trig),
        .sample_wr_o   (sample_wr),
        .tag_wr_o      (tag_wr),
        .acq_end_o     (acq_end),
        .shots_left_o  (shots_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then observe the registered outputs 1 ns later and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sample_wr === 1'b1) wr_cnt++;
        if (tag_wr === 1'b1) tag_cnt++;
        if (acq_end === 1'b1) acq_cnt++;
    endtask

    task automatic clear_tallies();
        wr_cnt  = 0;
        tag_cnt = 0;
        acq_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; trig = 1'b0; sample_valid = 1'b1;
        pre_samples = 32'd0; post_samples = 32'd1; shots = 16'd1;
        tick(); tick();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state); end
        n_checks++; if ({sample_wr, tag_wr, acq_end, wait_trig} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b exp 0000", {sample_wr, tag_wr, acq_end, wait_trig}); end
        n_checks++; if (shots_left !== 16'd0) begin n_fail++; $display("FAIL reset_shots_left: got %0d exp 0", shots_left); end
        n_checks++; if (cfg_ok !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ok: got %b exp 1", cfg_ok); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_release_state: got %0d exp 0", state); end
    endtask

    task automatic test_basic_single_shot();
        pre_samples = 32'd0; post_samples = 32'd1; shots = 16'd1; sample_valid = 1'b1;
        clear_tallies();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL basic_pre_state: got %0d exp 1", state); end
        n_checks++; if (shots_left !== 16'd1) begin n_fail++; $display("FAIL basic_shots_left_load: got %0d exp 1", shots_left); end
        tick();
        n_checks++; if (state !== 3'd2 || wait_trig !== 1'b1) begin n_fail++; $display("FAIL basic_wait_entry: got state %0d wait %b exp 2 1", state, wait_trig); end
        sample_valid = 1'b0;
        repeat (18) tick();
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL basic_wait_hold: got %0d exp 2", state); end
        sample_valid = 1'b1; trig = 1'b1; tick(); trig = 1'b0;
        n_checks++; if (state !== 3'd3 || wait_trig !== 1'b0) begin n_fail++; $display("FAIL basic_post_entry: got state %0d wait %b exp 3 0", state, wait_trig); end
        tick();
        n_checks++; if (state !== 3'd4 || tag_wr !== 1'b1) begin n_fail++; $display("FAIL basic_tag_wr: got state %0d tag %b exp 4 1", state, tag_wr); end
        tick();
        n_checks++; if (state !== 3'd5 || tag_wr !== 1'b0 || shots_left !== 16'd1) begin n_fail++; $display("FAIL basic_next_shot: got state %0d tag %b left %0d exp 5 0 1", state, tag_wr, shots_left); end
        tick();
        n_checks++; if (state !== 3'd0 || acq_end !== 1'b1 || shots_left !== 16'd0) begin n_fail++; $display("FAIL basic_acq_end: got state %0d end %b left %0d exp 0 1 0", state, acq_end, shots_left); end
        tick();
        n_checks++; if (acq_end !== 1'b0) begin n_fail++; $display("FAIL basic_acq_end_width: got %b exp 0", acq_end); end
        // one pre-phase sample, the trigger sample and one post sample
        n_checks++; if (wr_cnt !== 3 || tag_cnt !== 1 || acq_cnt !== 1) begin n_fail++; $display("FAIL basic_tallies: got wr %0d tag %0d end %0d exp 3 1 1", wr_cnt, tag_cnt, acq_cnt); end
    endtask

    task automatic test_multi_shot();
        pre_samples = 32'd4; post_samples = 32'd8; shots = 16'd3; sample_valid = 1'b1;
        clear_tallies();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (shots_left !== 16'd3) begin n_fail++; $display("FAIL multi_shots_load: got %0d exp 3", shots_left); end
        for (int s = 0; s < 3; s++) begin
            repeat (4) tick();
            n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL multi_wait_shot%0d: got %0d exp 2", s, state); end
            trig = 1'b1; tick(); trig = 1'b0;
            repeat (7) tick();
            n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL multi_post_hold_shot%0d: got %0d exp 3", s, state); end
            tick();
            n_checks++; if (state !== 3'd4 || tag_wr !== 1'b1) begin n_fail++; $display("FAIL multi_tag_shot%0d: got state %0d tag %b exp 4 1", s, state, tag_wr); end
            n_checks++; if (wr_cnt !== 13 * (s + 1)) begin n_fail++; $display("FAIL multi_writes_shot%0d: got %0d exp %0d", s, wr_cnt, 13 * (s + 1)); end
            tick();
            n_checks++; if (shots_left !== 16'(3 - s)) begin n_fail++; $display("FAIL multi_left_before_shot%0d: got %0d exp %0d", s, shots_left, 3 - s); end
            tick();
            if (s < 2) begin
                n_checks++; if (state !== 3'd1 || shots_left !== 16'(2 - s) || acq_end !== 1'b0) begin n_fail++; $display("FAIL multi_next_shot%0d: got state %0d left %0d end %b exp 1 %0d 0", s, state, shots_left, acq_end, 2 - s); end
            end else begin
                n_checks++; if (state !== 3'd0 || shots_left !== 16'd0 || acq_end !== 1'b1) begin n_fail++; $display("FAIL multi_run_end: got state %0d left %0d end %b exp 0 0 1", state, shots_left, acq_end); end
            end
        end
        tick();
        n_checks++; if (tag_cnt !== 3 || acq_cnt !== 1 || wr_cnt !== 39) begin n_fail++; $display("FAIL multi_tallies: got tag %0d end %0d wr %0d exp 3 1 39", tag_cnt, acq_cnt, wr_cnt); end
    endtask

    task automatic test_early_trigger();
        pre_samples = 32'd16; post_samples = 32'd1; shots = 16'd1; sample_valid = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        trig = 1'b1;
        repeat (15) tick();
        n_checks++; if (state !== 3'd1 || wait_trig !== 1'b0) begin n_fail++; $display("FAIL early_trig_ignored: got state %0d wait %b exp 1 0", state, wait_trig); end
        tick();
        trig = 1'b0;
        n_checks++; if (state !== 3'd2 || wait_trig !== 1'b1) begin n_fail++; $display("FAIL early_trig_wait_entry: got state %0d wait %b exp 2 1", state, wait_trig); end
        stop = 1'b1; tick(); stop = 1'b0;
        n_checks++; if (state !== 3'd0 || wait_trig !== 1'b0) begin n_fail++; $display("FAIL early_trig_stop: got state %0d wait %b exp 0 0", state, wait_trig); end
    endtask

    task automatic test_abort();
        pre_samples = 32'd0; post_samples = 32'd8; shots = 16'd2; sample_valid = 1'b1;
        clear_tallies();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (3) tick();
        n_checks++; if (state !== 3'd3 || shots_left !== 16'd2) begin n_fail++; $display("FAIL abort_pre_stop: got state %0d left %0d exp 3 2", state, shots_left); end
        stop = 1'b1; tick(); stop = 1'b0;
        n_checks++; if (state !== 3'd0 || shots_left !== 16'd0 || acq_end !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got state %0d left %0d end %b exp 0 0 0", state, shots_left, acq_end); end
        repeat (4) tick();
        n_checks++; if (tag_cnt !== 0 || acq_cnt !== 0) begin n_fail++; $display("FAIL abort_no_pulses: got tag %0d end %0d exp 0 0", tag_cnt, acq_cnt); end
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        n_checks++; if (state !== 3'd0 || shots_left !== 16'd0) begin n_fail++; $display("FAIL start_stop_same_cycle: got state %0d left %0d exp 0 0", state, shots_left); end
    endtask

    task automatic test_bad_config();
        pre_samples = 32'd0; post_samples = 32'd5; shots = 16'd0; sample_valid = 1'b1;
        #1;
        n_checks++; if (cfg_ok !== 1'b0) begin n_fail++; $display("FAIL cfg_shots_zero: got %b exp 0", cfg_ok); end
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL cfg_shots_zero_start: got %0d exp 0", state); end
        post_samples = 32'd0; shots = 16'd2;
        #1;
        n_checks++; if (cfg_ok !== 1'b0) begin n_fail++; $display("FAIL cfg_post_zero: got %b exp 0", cfg_ok); end
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (state !== 3'd0 || shots_left !== 16'd0) begin n_fail++; $display("FAIL cfg_post_zero_start: got state %0d left %0d exp 0 0", state, shots_left); end
        // post_samples changed after the start still ends the shot on the latched count
        post_samples = 32'd2; shots = 16'd1;
        clear_tallies();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        trig = 1'b1; tick(); trig = 1'b0;
        post_samples = 32'd10; shots = 16'd7;
        tick();
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL cfg_latched_post_hold: got %0d exp 3", state); end
        tick();
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL cfg_latched_post_end: got %0d exp 4", state); end
        tick(); tick();
        n_checks++; if (state !== 3'd0 || acq_end !== 1'b1 || shots_left !== 16'd0) begin n_fail++; $display("FAIL cfg_latched_shots: got state %0d end %b left %0d exp 0 1 0", state, acq_end, shots_left); end
    endtask

    task automatic test_reset_mid_run();
        pre_samples = 32'd0; post_samples = 32'd4; shots = 16'd2; sample_valid = 1'b1;
        clear_tallies();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_checks++; if (state !== 3'd2 || shots_left !== 16'd2) begin n_fail++; $display("FAIL rst_mid_pre: got state %0d left %0d exp 2 2", state, shots_left); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_checks++; if (state !== 3'd0 || shots_left !== 16'd0) begin n_fail++; $display("FAIL rst_mid_state: got state %0d left %0d exp 0 0", state, shots_left); end
        n_checks++; if ({sample_wr, tag_wr, acq_end, wait_trig} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_pulses: got %b exp 0000", {sample_wr, tag_wr, acq_end, wait_trig}); end
        trig = 1'b1; tick(); trig = 1'b0;
        n_checks++; if (state !== 3'd0 || sample_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_trig_ignored: got state %0d wr %b exp 0 0", state, sample_wr); end
        repeat (3) tick();
        n_checks++; if (tag_cnt !== 0 || acq_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_pulses: got tag %0d end %0d exp 0 0", tag_cnt, acq_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_single_shot();
        test_multi_shot();
        test_early_trigger();
        test_abort();
        test_bad_config();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fmc_adc_shot_sequencer.md
# fmc_adc_shot_sequencer

Multi-shot acquisition sequencer for the FMC-ADC 100 MS/s core, in the sampling clock domain between the trigger arbitration logic and the DDR sample-buffer writer. It latches the pre/post-sample and shot configuration at start, counts samples through the pre-trigger, wait-trigger and post-trigger phases, and requests a timetag write at the end of each shot. It issues one end-of-acquisition pulse per completed run; that pulse drives the ACQ_END interrupt through the EIC.

## Interface
- g_SAMPLE_CNT_WIDTH, 32: width of the pre/post sample counters.
- g_SHOT_CNT_WIDTH, 16: width of the shot counter.

- clk_i  in  1  sampling clock; every register is in this domain.
- rst_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  single-cycle start command (CSR CTL FSM start).
- stop_i  in  1  single-cycle abort command.
- pre_samples_i  in  g_SAMPLE_CNT_WIDTH  pre-trigger sample count.
- post_samples_i  in  g_SAMPLE_CNT_WIDTH  post-trigger sample count, excluding the trigger sample.
- shots_i  in  g_SHOT_CNT_WIDTH  number of shots.
- sample_valid_i  in  1  strobe, one cycle per ADC sample.
- trig_i  in  1  arbitrated trigger pulse (software, channel, external or time source).
- cfg_ok_o  out  1  configuration valid.
- state_o  out  3  current state encoding.
- wait_trig_o  out  1  high while in WAIT_TRIG.
- sample_wr_o  out  1  buffer write enable.
- tag_wr_o  out  1  timetag write request.
- acq_end_o  out  1  end-of-run pulse.
- shots_left_o  out  g_SHOT_CNT_WIDTH  remaining shots, including the current one.

## Operation
- cfg_ok_o = (shots_i != 0) and (post_samples_i != 0). It is combinational on the live inputs.
- States and encodings: IDLE=0, PRE_TRIG=1, WAIT_TRIG=2, POST_TRIG=3, TAG_WR=4, NEXT_SHOT=5.
- IDLE
  - If start_i and cfg_ok_o: latch pre/post/shots, load shots_left_o = shots_i, then go to PRE_TRIG.
  - Otherwise start_i is ignored.
- PRE_TRIG
  - Count sample_valid_i. Leave for WAIT_TRIG in the cycle after the pre_samples-th sample.
  - If the latched pre_samples is 0, go to WAIT_TRIG immediately (one cycle in PRE_TRIG).
  - trig_i is ignored in this state.
- WAIT_TRIG
  - On trig_i, go to POST_TRIG. A sample_valid_i coincident with trig_i is the trigger sample; it is written but not counted.
  - trig_i with no sample_valid_i still moves to POST_TRIG.
- POST_TRIG: count sample_valid_i. Leave for TAG_WR in the cycle after the post_samples-th sample. trig_i is ignored.
- TAG_WR: one cycle; tag_wr_o is high for exactly this cycle. Then go to NEXT_SHOT.
- NEXT_SHOT
  - If shots_left_o == 1: pulse acq_end_o, set shots_left_o = 0, go to IDLE.
  - Otherwise decrement shots_left_o and go to PRE_TRIG. Sample counters restart from 0.
- sample_wr_o is registered: high in cycle N+1 when sample_valid_i was high in cycle N and the state in cycle N was PRE_TRIG, WAIT_TRIG or POST_TRIG.
- stop_i in any non-IDLE state forces IDLE on the next cycle.
  - No acq_end_o and no tag_wr_o are issued.
  - shots_left_o is cleared.
- start_i and stop_i in the same cycle: stop_i wins and the state stays IDLE.
- Configuration inputs changing mid-run have no effect until the next start.
- Counters compare with equality against latched values. Width rollover cannot occur because the count stops at the target.

## Timing
- Reset: state IDLE; sample_wr_o, tag_wr_o, acq_end_o and wait_trig_o all 0; shots_left_o 0; counters 0.
- A reset asserted mid-run returns the block to IDLE on the next edge with no pulses emitted.
- state_o, wait_trig_o, tag_wr_o, acq_end_o and shots_left_o are registered.
- start_i in cycle N gives PRE_TRIG in cycle N+1.
- trig_i in WAIT_TRIG in cycle N gives POST_TRIG in cycle N+1.
- acq_end_o is high for exactly one cycle: the cycle after the last NEXT_SHOT.
- Minimum run length for pre=0, post=1, shots=1 with continuous sample_valid_i:
  - IDLE, PRE_TRIG, WAIT_TRIG, trigger, POST_TRIG (1 sample), TAG_WR, NEXT_SHOT, IDLE.

## Structure
- Package fmc_adc_shot_seq_pkg holds the state enum (t_shot_seq_state, 3-bit) and the encoding constants, shared with the CSR status FSM field.
- One sub-module, fmc_adc_sample_counter: loadable up-counter with a target-equality flag. It is instantiated twice (pre and post).

## Test plan
- Basic single shot: pre=0, post=1, shots=1, continuous samples, trig_i 20 cycles after start → 2 sample_wr_o in POST/trigger, 1 tag_wr_o, 1 acq_end_o, shots_left_o 1→0.
- Multi-shot: pre=4, post=8, shots=3, three triggers → per shot 4 pre + 1 trigger + 8 post = 13 writes, 3 tag_wr_o, a single acq_end_o after the third shot, shots_left_o 3→2→1→0.
- Early trigger: trig_i during PRE_TRIG (pre=16) → ignored, state stays PRE_TRIG until 16 samples, wait_trig_o then high.
- Abort: stop_i in POST_TRIG after 3 of 8 samples → IDLE next cycle, no tag_wr_o, no acq_end_o, shots_left_o=0. Also start_i+stop_i in the same cycle → stays IDLE.
- Bad configuration: start_i with shots=0 or post=0 → cfg_ok_o=0, state stays IDLE. Changing post_samples_i mid-run → current shot still uses the latched value.
- Reset mid-run: rst_n_i low for 1 cycle in WAIT_TRIG → all outputs at reset values, subsequent trig_i ignored.
